// File: rtl/spi_reg_ctrl_if.sv
// Byte-level handshake bundle: SPI shifter rx/tx bytes plus the single local write requester.
interface spi_reg_ctrl_if;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_req;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       loc_req;
  logic [6:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_gnt;

  modport master (
    output frame_active, rx_valid, rx_byte, tx_req,
    output loc_req, loc_addr, loc_wdata,
    input  tx_byte, tx_valid, loc_gnt
  );

  modport slave (
    input  frame_active, rx_valid, rx_byte, tx_req,
    input  loc_req, loc_addr, loc_wdata,
    output tx_byte, tx_valid, loc_gnt
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI register-bank transaction sequencer: command decode, auto-increment streaming
// reads/writes, whole-byte transmit snapshots and SPI-priority local write arbitration.
module spi_reg_ctrl #(
  parameter int unsigned RW_REG_COUNT = 8,
  parameter int unsigned RO_REG_COUNT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  spi_reg_ctrl_if.slave             bus,
  output logic [RW_REG_COUNT*8-1:0] rw_data,
  input  logic [RO_REG_COUNT*8-1:0] ro_data,
  output logic                      busy,
  output logic                      err,
  input  logic                      clr_err
);

  localparam int unsigned TOTAL   = RW_REG_COUNT + RO_REG_COUNT;
  localparam logic [7:0]  RW_END  = 8'(RW_REG_COUNT);
  localparam logic [6:0]  LAST    = 7'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t     state, state_nxt;
  logic [6:0] addr, addr_nxt;
  logic [7:0] rw_q   [RW_REG_COUNT];
  logic [7:0] rw_nxt [RW_REG_COUNT];
  logic [7:0] tx_byte_q, tx_byte_nxt;
  logic       tx_valid_q, tx_valid_nxt;
  logic       rd_first, rd_first_nxt;
  logic       err_q, err_nxt;
  logic       busy_q;

  logic [7:0] rd_byte;
  logic [6:0] addr_inc;
  logic       spi_wr;
  logic       loc_wr;
  logic       err_set;
  logic       loc_gnt_c;

  // SPI owns the bank in any cycle it is writing
  assign loc_gnt_c   = bus.loc_req && !((state == WRITE) && bus.rx_valid);
  assign bus.loc_gnt = loc_gnt_c;

  // Bank read mux; holes above TOTAL read as zero
  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < int'(RW_REG_COUNT); i++) begin
      if (addr == 7'(i)) rd_byte = rw_q[i];
    end
    for (int j = 0; j < int'(RO_REG_COUNT); j++) begin
      if (addr == 7'(int'(RW_REG_COUNT) + j)) rd_byte = ro_data[8*j +: 8];
    end
  end

  // Last bank byte wraps to 0; out-of-range addresses roll over naturally mod 128
  assign addr_inc = (addr == LAST) ? 7'd0 : addr + 7'd1;

  // Next-state and datapath updates
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    rw_nxt       = rw_q;
    tx_byte_nxt  = tx_byte_q;
    tx_valid_nxt = tx_valid_q;
    rd_first_nxt = 1'b0;
    spi_wr       = 1'b0;
    loc_wr       = 1'b0;
    err_set      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.frame_active) state_nxt = CMD;
      end
      CMD: begin
        if (bus.rx_valid) begin
          addr_nxt = bus.rx_byte[6:0];
          if (bus.rx_byte[7]) begin
            state_nxt    = READ;
            rd_first_nxt = 1'b1;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.rx_valid) begin
          if ({1'b0, addr} < RW_END) spi_wr = 1'b1;
          else                       err_set = 1'b1;
          addr_nxt = addr_inc;
        end
      end
      READ: begin
        if (bus.frame_active && (rd_first || bus.tx_req)) begin
          tx_byte_nxt  = rd_byte;
          tx_valid_nxt = 1'b1;
          addr_nxt     = addr_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Chip-select release ends the frame from any active state
    if ((state != IDLE) && !bus.frame_active) begin
      state_nxt    = IDLE;
      tx_valid_nxt = 1'b0;
      rd_first_nxt = 1'b0;
    end

    if (loc_gnt_c) begin
      if ({1'b0, bus.loc_addr} < RW_END) loc_wr = 1'b1;
      else                               err_set = 1'b1;
    end

    for (int i = 0; i < int'(RW_REG_COUNT); i++) begin
      if (spi_wr && (addr == 7'(i)))          rw_nxt[i] = bus.rx_byte;
      if (loc_wr && (bus.loc_addr == 7'(i)))  rw_nxt[i] = bus.loc_wdata;
    end

    err_nxt = err_set | (err_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      rw_q       <= '{default: '0};
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_first   <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      rw_q       <= rw_nxt;
      tx_byte_q  <= tx_byte_nxt;
      tx_valid_q <= tx_valid_nxt;
      rd_first   <= rd_first_nxt;
      err_q      <= err_nxt;
      busy_q     <= (state_nxt != IDLE);
    end
  end

  for (genvar g = 0; g < int'(RW_REG_COUNT); g++) begin : g_flat
    assign rw_data[8*g +: 8] = rw_q[g];
  end

  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: bank model, tx scoreboard queue, arbitration and reset cases.
module tb_spi_reg_ctrl;

  logic        clk;
  logic        rst;
  logic [63:0] rw_data;
  logic [31:0] ro_data;
  logic        busy;
  logic        err;
  logic        clr_err;

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl #(.RW_REG_COUNT(8), .RO_REG_COUNT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .rw_data (rw_data),
    .ro_data (ro_data),
    .busy    (busy),
    .err     (err),
    .clr_err (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_rw [8];
  logic        exp_err;
  logic [6:0]  maddr;
  logic [7:0]  sb [$];
  logic [7:0]  last_exp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_rw();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = exp_rw[i];
    return v;
  endfunction

  function automatic logic [7:0] model_byte(input logic [6:0] a);
    logic [31:0] sh;
    if (a < 7'd8) return exp_rw[a[2:0]];
    if (a < 7'd12) begin
      sh = ro_data >> (8 * (int'(a) - 8));
      return sh[7:0];
    end
    return 8'h00;
  endfunction

  function automatic logic [6:0] model_adv(input logic [6:0] a);
    return (a == 7'd11) ? 7'd0 : a + 7'd1;
  endfunction

  task automatic frame_open(input logic [7:0] cmd);
    bus.frame_active = 1'b1;
    tick();
    bus.rx_valid = 1'b1;
    bus.rx_byte  = cmd;
    maddr        = cmd[6:0];
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic frame_close();
    bus.frame_active = 1'b0;
    tick();
    check_eq("busy_after_close", 64'(busy), 64'd0);
    check_eq("tx_valid_after_close", 64'(bus.tx_valid), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    if (maddr < 7'd8) exp_rw[maddr[2:0]] = b;
    else              exp_err = 1'b1;
    maddr = model_adv(maddr);
    tick();
    bus.rx_valid = 1'b0;
    check_eq("rw_data_wr", rw_data, model_rw());
  endtask

  task automatic sb_check();
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      last_exp = sb.pop_front();
      check_eq("tx_byte", 64'(bus.tx_byte), 64'(last_exp));
      check_eq("tx_valid", 64'(bus.tx_valid), 64'd1);
    end
  endtask

  task automatic read_open(input logic [7:0] cmd);
    frame_open(cmd);
    sb.push_back(model_byte(maddr));
    maddr = model_adv(maddr);
    tick();
    sb_check();
  endtask

  task automatic read_next();
    bus.tx_req = 1'b1;
    sb.push_back(model_byte(maddr));
    maddr = model_adv(maddr);
    tick();
    bus.tx_req = 1'b0;
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    clr_err          = 1'b0;
    ro_data          = 32'h1312_1110;
    bus.frame_active = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_byte      = 8'h00;
    bus.tx_req       = 1'b0;
    bus.loc_req      = 1'b0;
    bus.loc_addr     = 7'd0;
    bus.loc_wdata    = 8'h00;
    for (int i = 0; i < 8; i++) exp_rw[i] = 8'h00;
    exp_err = 1'b0;
    maddr   = 7'd0;
    last_exp = 8'h00;

    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_rw_data", rw_data, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check_eq("rst_tx_byte", 64'(bus.tx_byte), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);

    // Streaming write from address 2
    frame_open(8'h02);
    check_eq("busy_in_frame", 64'(busy), 64'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    frame_close();
    check_eq("wr_stream_const", rw_data, 64'h0000_00CC_BBAA_0000);
    check_eq("wr_stream_err", 64'(err), 64'd0);

    frame_open(8'h00);
    send_byte(8'h5A);
    send_byte(8'hA5);
    frame_close();

    // Read across the RO region with wrap from 11 to 0
    read_open(8'h8A);
    read_next();
    read_next();
    read_next();
    frame_close();

    // Snapshot holds while ro_data changes
    read_open(8'h88);
    ro_data = 32'h5352_5150;
    tick();
    tick();
    check_eq("snapshot_hold", 64'(bus.tx_byte), 64'(last_exp));
    read_next();
    frame_close();

    // Out-of-range address reads zero, then rolls over to 0
    read_open(8'hFF);
    read_next();
    frame_close();

    // Write to the last RW byte, then overflow drops and flags
    frame_open(8'h07);
    send_byte(8'h11);
    send_byte(8'h22);
    frame_close();
    check_eq("drop_err", 64'(err), 64'(exp_err));
    check_eq("drop_rw7", 64'(rw_data[63:56]), 64'h11);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    exp_err = 1'b0;
    check_eq("clr_err", 64'(err), 64'd0);

    // Local write to RO address with clr_err: set wins
    bus.loc_req   = 1'b1;
    bus.loc_addr  = 7'd9;
    bus.loc_wdata = 8'h66;
    clr_err       = 1'b1;
    #1;
    check_eq("loc_gnt_idle", 64'(bus.loc_gnt), 64'd1);
    tick();
    bus.loc_req = 1'b0;
    clr_err     = 1'b0;
    check_eq("set_wins_err", 64'(err), 64'd1);
    check_eq("loc_drop_rw", rw_data, model_rw());
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("clr_err2", 64'(err), 64'd0);

    // Arbitration: SPI write to address 3 beats the local requester
    frame_open(8'h03);
    bus.rx_valid  = 1'b1;
    bus.rx_byte   = 8'h77;
    bus.loc_req   = 1'b1;
    bus.loc_addr  = 7'd3;
    bus.loc_wdata = 8'h99;
    #1;
    check_eq("loc_gnt_blocked", 64'(bus.loc_gnt), 64'd0);
    exp_rw[3] = 8'h77;
    maddr = model_adv(maddr);
    tick();
    bus.rx_valid = 1'b0;
    #1;
    check_eq("spi_first_rw", rw_data, model_rw());
    check_eq("loc_gnt_after", 64'(bus.loc_gnt), 64'd1);
    exp_rw[3] = 8'h99;
    @(posedge clk);
    #1;
    bus.loc_req = 1'b0;
    check_eq("loc_wr_rw", rw_data, model_rw());
    frame_close();

    // Reset mid-write overrides the in-flight byte
    frame_open(8'h00);
    send_byte(8'h33);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h44;
    rst          = 1'b1;
    tick();
    rst              = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.frame_active = 1'b0;
    for (int i = 0; i < 8; i++) exp_rw[i] = 8'h00;
    check_eq("midrst_rw", rw_data, 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);

    // Chip-select drop mid-read clears tx_valid
    read_open(8'h80);
    frame_close();

    check_eq("sb_left", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
